// File: rtl/letter_sequencer.sv
// -----------------------------------------------------------------------------
// letter_sequencer
//
// Scrolls the message "UFERSA" followed by NUM_DIGITS blanks across a bank of
// NUM_DIGITS seven-segment letter decoders. Each digit receives a 3-bit letter
// code: U=000 F=001 E=010 R=011 S=100 A=101, blank=111.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   pulse: (re)start scrolling from position 0
//   stop        in   pulse: return to idle, all digits blank
//   pause_tgl   in   pulse: toggle RUN <-> PAUSE
//   step        in   pulse: advance one position (PAUSE only)
//   digit_codes out  3*NUM_DIGITS letter codes, digit i at [3i+2:3i], digit 0 leftmost
//   running     out  high while in RUN (registered)
//   step_pulse  out  one-cycle pulse, coincident with the new position
//   wrap        out  one-cycle pulse when an advance lands on position 0
//
// Command handshake: all command inputs are single-cycle pulses sampled on the
// rising edge; when several coincide the priority is stop > start > pause_tgl
// > step. Outputs step_pulse/wrap act as a valid strobe with no ready.
// -----------------------------------------------------------------------------
module letter_sequencer #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 50000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      pause_tgl,
   input  logic                      step,
   output logic [3*NUM_DIGITS-1:0]   digit_codes,
   output logic                      running,
   output logic                      step_pulse,
   output logic                      wrap
);

   localparam int L  = 6 + NUM_DIGITS;
   localparam int PW = $clog2(L);
   localparam int CW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [PW-1:0]   pos, pos_n, pos_inc;
   logic [CW-1:0]   cnt, cnt_n;
   logic            adv;
   int              idx;

   assign pos_inc = (pos == PW'(L - 1)) ? '0 : pos + PW'(1);

   // Next-state / next-position / tick counter logic.
   always_comb begin
      state_n = state;
      pos_n   = pos;
      cnt_n   = cnt;
      adv     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               pos_n   = '0;
               cnt_n   = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_n = IDLE;
               pos_n   = '0;
               cnt_n   = '0;
            end else if (start) begin
               pos_n   = '0;
               cnt_n   = '0;
            end else if (pause_tgl) begin
               // Counter is frozen; a terminal count in this cycle is dropped.
               state_n = PAUSE;
            end else if (cnt == CW'(TICK_DIV - 1)) begin
               cnt_n   = '0;
               pos_n   = pos_inc;
               adv     = 1'b1;
            end else begin
               cnt_n   = cnt + CW'(1);
            end
         end
         PAUSE: begin
            if (stop) begin
               state_n = IDLE;
               pos_n   = '0;
               cnt_n   = '0;
            end else if (start) begin
               state_n = RUN;
               pos_n   = '0;
               cnt_n   = '0;
            end else if (pause_tgl) begin
               // Resume with the held count so the interrupted period completes.
               state_n = RUN;
            end else if (step) begin
               pos_n   = pos_inc;
               adv     = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            pos_n   = '0;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pos        <= '0;
         cnt        <= '0;
         running    <= 1'b0;
         step_pulse <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         state      <= state_n;
         pos        <= pos_n;
         cnt        <= cnt_n;
         running    <= (state_n == RUN);
         step_pulse <= adv;
         wrap       <= adv && (pos_n == '0);
      end
   end

   // Window of NUM_DIGITS letters starting at pos into the circular message.
   // pos < L and i < L, so one conditional subtraction gives the modulo.
   always_comb begin
      digit_codes = '1;
      idx         = 0;
      if (state != IDLE) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            idx = int'(pos) + i;
            if (idx >= L) idx = idx - L;
            if (idx < 6) digit_codes[3*i +: 3] = 3'(idx);
            else         digit_codes[3*i +: 3] = 3'b111;
         end
      end
   end

endmodule

// File: tb/tb_letter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_letter_sequencer
//
// Directed bench for letter_sequencer with NUM_DIGITS=4, TICK_DIV=4 (L=10).
// The driver pushes the expected {wrap, digit_codes} of every advance into
// exp_q; a monitor pops and compares whenever step_pulse (or wrap) is seen.
// Direct checks cover reset state, running, idle behaviour and key windows.
// -----------------------------------------------------------------------------
module tb_letter_sequencer;

   localparam int ND = 4;
   localparam int TD = 4;
   localparam int LL = 6 + ND;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              pause_tgl = 1'b0;
   logic              step = 1'b0;
   logic [3*ND-1:0]   digit_codes;
   logic              running;
   logic              step_pulse;
   logic              wrap;

   int                checks = 0;
   int                failures = 0;
   int                exp_pos = 0;
   logic [3*ND:0]     exp_q[$];

   letter_sequencer #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pause_tgl   (pause_tgl),
      .step        (step),
      .digit_codes (digit_codes),
      .running     (running),
      .step_pulse  (step_pulse),
      .wrap        (wrap)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   // Window of ND letters starting at p; digit 0 in the low bits.
   function automatic logic [3*ND-1:0] window(input int p);
      logic [3*ND-1:0] w;
      int k;
      w = '1;
      for (int i = 0; i < ND; i++) begin
         k = (p + i) % LL;
         w[3*i +: 3] = (k < 6) ? 3'(k) : 3'b111;
      end
      return w;
   endfunction

   task automatic expect_adv();
      exp_pos = (exp_pos == LL - 1) ? 0 : exp_pos + 1;
      exp_q.push_back({(exp_pos == 0), window(exp_pos)});
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [3*ND:0] e;
      if (step_pulse === 1'b1 || wrap === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_advance actual=%h expected=none",
                     {wrap, digit_codes});
         end else begin
            e = exp_q.pop_front();
            if ({wrap, digit_codes} !== e || step_pulse !== 1'b1) begin
               failures++;
               $display("FAIL advance actual=%h/%b expected=%h/1",
                        {wrap, digit_codes}, step_pulse, e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // 1. reset and idle behaviour
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      check("rst_digits", 32'(digit_codes), 32'hFFF);
      check("rst_running", 32'(running), 0);
      check("rst_step_pulse", 32'(step_pulse), 0);
      check("rst_wrap", 32'(wrap), 0);
      pause_tgl = 1'b1; cyc(); pause_tgl = 1'b0;
      step = 1'b1; cyc(); step = 1'b0;
      stop = 1'b1; cyc(); stop = 1'b0;
      cyc();
      check("idle_digits", 32'(digit_codes), 32'hFFF);
      check("idle_running", 32'(running), 0);

      // 2. start, first advance after TICK_DIV cycles
      start = 1'b1; cyc(); start = 1'b0;
      exp_pos = 0;
      check("start_digits", 32'(digit_codes), 32'h688);
      check("start_running", 32'(running), 1);
      check("start_no_pulse", 32'(step_pulse), 0);
      expect_adv();
      repeat (TD - 1) cyc();
      check("pre_adv_digits", 32'(digit_codes), 32'h688);
      check("pre_adv_pulse", 32'(step_pulse), 0);
      cyc();
      check("adv1_digits", 32'(digit_codes), 32'h8D1);
      check("adv1_pulse", 32'(step_pulse), 1);

      // 3. scroll through to the wrap
      for (int a = 0; a < LL - 1; a++) begin
         expect_adv();
         repeat (TD) cyc();
         if (exp_pos == 6) check("pos6_digits", 32'(digit_codes), 32'hFFF);
         if (exp_pos == 8) check("pos8_digits", 32'(digit_codes), 32'h23F);
         if (exp_pos == 0) begin
            check("wrap_digits", 32'(digit_codes), 32'h688);
            check("wrap_flag", 32'(wrap), 1);
         end
      end
      cyc();
      check("wrap_one_cycle", 32'(wrap), 0);

      // 4. pause when cnt=3 (cnt now 1 after the extra cycle above)
      cyc(); cyc();
      pause_tgl = 1'b1; cyc(); pause_tgl = 1'b0;
      check("pause_running", 32'(running), 0);
      check("pause_no_pulse", 32'(step_pulse), 0);
      check("pause_digits", 32'(digit_codes), 32'h688);
      repeat (6) cyc();
      check("pause_stable", 32'(digit_codes), 32'h688);
      for (int s = 0; s < 3; s++) begin
         expect_adv();
         step = 1'b1; cyc(); step = 1'b0;
         check("step_pulse", 32'(step_pulse), 1);
         cyc();
      end
      check("after_steps_digits", 32'(digit_codes), 32'hF63);
      expect_adv();
      pause_tgl = 1'b1; cyc(); pause_tgl = 1'b0;
      check("resume_running", 32'(running), 1);
      check("resume_no_pulse", 32'(step_pulse), 0);
      cyc();
      check("resume_adv_pulse", 32'(step_pulse), 1);
      check("resume_adv_digits", 32'(digit_codes), 32'hFEC);

      // 5. stop+start together in RUN -> IDLE; start in PAUSE at pos 7
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      check("stopstart_digits", 32'(digit_codes), 32'hFFF);
      check("stopstart_running", 32'(running), 0);
      repeat (5) cyc();
      start = 1'b1; cyc(); start = 1'b0;
      exp_pos = 0;
      pause_tgl = 1'b1; cyc(); pause_tgl = 1'b0;
      for (int s = 0; s < 7; s++) begin
         expect_adv();
         step = 1'b1; cyc(); step = 1'b0;
      end
      check("pos7_digits", 32'(digit_codes), 32'h1FF);
      check("pos7_running", 32'(running), 0);
      start = 1'b1; cyc(); start = 1'b0;
      exp_pos = 0;
      check("restart_digits", 32'(digit_codes), 32'h688);
      check("restart_running", 32'(running), 1);
      check("restart_no_pulse", 32'(step_pulse), 0);
      expect_adv();
      repeat (TD - 1) cyc();
      check("restart_cnt0", 32'(step_pulse), 0);
      cyc();
      check("restart_adv_digits", 32'(digit_codes), 32'h8D1);

      // 6. reset mid-RUN at pos 5 with cnt=2
      for (int a = 0; a < 4; a++) begin
         expect_adv();
         repeat (TD) cyc();
      end
      cyc(); cyc();
      check("pos5_digits", 32'(digit_codes), 32'hFFD);
      rst = 1'b1; cyc(); rst = 1'b0;
      check("midrst_digits", 32'(digit_codes), 32'hFFF);
      check("midrst_running", 32'(running), 0);
      check("midrst_pulse", 32'(step_pulse), 0);
      check("midrst_wrap", 32'(wrap), 0);
      repeat (5) cyc();
      check("midrst_idle", 32'(digit_codes), 32'hFFF);
      start = 1'b1; cyc(); start = 1'b0;
      exp_pos = 0;
      check("post_rst_start", 32'(digit_codes), 32'h688);
      expect_adv();
      repeat (TD) cyc();
      check("post_rst_adv", 32'(digit_codes), 32'h8D1);

      // report
      repeat (3) cyc();
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/letter_sequencer.md
Name: letter_sequencer

Overview:
- Upstream stage of the 7-segment letter decoders.
- Generates the 3-bit letter codes for a bank of NUM_DIGITS displays so that the message "UFERSA" scrolls across them, followed by blank padding.
- One decoder instance per digit consumes one 3-bit field of digit_codes.
- Code map (fixed by the decoder): U=000, F=001, E=010, R=011, S=100, A=101; 111 = blank.

Parameters:
- NUM_DIGITS, 4, number of displays driven (1..8).
- TICK_DIV, 50000000, clock cycles per scroll step while running (>=2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: (re)start scrolling from position 0.
- stop  input  1  single-cycle pulse: return to idle, all digits blank.
- pause_tgl  input  1  single-cycle pulse: toggle between RUN and PAUSE.
- step  input  1  single-cycle pulse: advance one position, honoured only in PAUSE.
- digit_codes  output  3*NUM_DIGITS  letter codes; digit i occupies bits [3i+2:3i]; digit 0 is leftmost.
- running  output  1  high while in RUN.
- step_pulse  output  1  high for exactly one cycle each time the position advances.
- wrap  output  1  high for one cycle when an advance moves the position to 0.

Behaviour:
- Message buffer length L = 6 + NUM_DIGITS; msg[k] = k for k < 6, else 111.
- Position register pos has ceil(log2 L) bits, range 0..L-1; an advance takes L-1 to 0.
- Tick counter cnt has ceil(log2 TICK_DIV) bits, range 0..TICK_DIV-1.
- States: IDLE, RUN, PAUSE.
- Reset (rst=1 at an edge): state=IDLE, pos=0, cnt=0, running=0, step_pulse=0, wrap=0. digit_codes is all ones from the following cycle.
- Reset overrides every other input, including mid-RUN and mid-PAUSE.
- digit_codes is combinational from the registered state and pos, with zero added latency:
  - IDLE: every field = 111.
  - RUN or PAUSE: field i = msg[(pos+i) mod L].
- Command priority when pulses coincide: stop > start > pause_tgl > step.
- IDLE:
  - start -> RUN, pos=0, cnt=0.
  - pause_tgl, step and stop are ignored.
- RUN:
  - stop -> IDLE, pos=0, cnt=0.
  - start -> RUN, pos=0, cnt=0, no step_pulse.
  - pause_tgl -> PAUSE; cnt holds its value; no advance, even if cnt = TICK_DIV-1 in that cycle.
  - Otherwise, if cnt = TICK_DIV-1: cnt=0, pos advances.
  - Otherwise: cnt increments.
  - step is ignored.
- PAUSE:
  - stop -> IDLE, pos=0, cnt=0.
  - start -> RUN, pos=0, cnt=0.
  - pause_tgl -> RUN; cnt resumes from its held value.
  - step -> pos advances; cnt is unchanged.
- Advance timing:
  - step_pulse is registered and is high in the same cycle that pos shows its new value.
  - wrap is high in that same cycle when the new pos = 0.
  - Scroll period in RUN is exactly TICK_DIV cycles; the first advance occurs TICK_DIV cycles after the start pulse edge.
- running = (state == RUN), registered.
- No other outputs change in PAUSE; digit_codes is stable there.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, L=10):
1. Reset asserted, then released -> digit_codes=12'hFFF, running=0, step_pulse=0, wrap=0. Pulses of pause_tgl and step in IDLE -> no change.
2. start pulse at edge E0 -> digit_codes=12'h688 (U F E R), running=1. At edge E0+4: step_pulse=1 for one cycle, pos=1, digits F E R S = 12'h8D1.
3. Continue RUN -> at pos 6, digit_codes=12'hFFF. At pos 8, 12'h23F. On the 10th advance: wrap=1 for one cycle, pos=0, 12'h688 again.
4. pause_tgl in the cycle where cnt=3 -> PAUSE, pos unchanged, no step_pulse, running=0. Three step pulses -> pos +3 with three step_pulse cycles. pause_tgl -> RUN; next advance follows exactly one cycle later, because cnt held 3.
5. stop and start in the same cycle during RUN -> IDLE, digit_codes=12'hFFF, running=0. start alone during PAUSE at pos 7 -> RUN, pos=0, cnt=0, no step_pulse.
6. rst pulsed during RUN at pos 5 with cnt=2 -> next cycle IDLE, pos=0, cnt=0, 12'hFFF. The following start restarts cleanly from 12'h688.
